// File: rtl/dmem_bank_model_pkg.sv
// dmem_bank_model_pkg: shared widths, defaults and read-beat type for the data memory bank.
package dmem_bank_model_pkg;
  localparam int MEM_DATA_WIDTH      = 32;
  localparam int MEM_STRB_WIDTH      = MEM_DATA_WIDTH / 8;
  localparam int DMEM_CNT_WIDTH      = 16;
  localparam int DMEM_RD_LAT_DEFAULT = 1;
  typedef struct packed {
    logic                      valid;
    logic                      err;
    logic [MEM_DATA_WIDTH-1:0] data;
  } dmem_rd_beat_t;
endpackage

// File: rtl/dmem_bank_model_rd_pipe.sv
// dmem_rd_pipe: delay line of read beats; each stage keeps its data when an invalid beat passes.
module dmem_rd_pipe
  import dmem_bank_model_pkg::*;
#(
  parameter int  STAGES = 1,
  parameter type beat_t = dmem_rd_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  beat_t beat_i,
  output beat_t beat_o
);
  beat_t stg_q [STAGES];
  beat_t stg_d [STAGES];
  always_comb begin
    stg_d[0] = beat_i;
    for (int i = 1; i < STAGES; i++) stg_d[i] = stg_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
    else for (int i = 0; i < STAGES; i++)
      if (stg_d[i].valid) stg_q[i] <= stg_d[i];
      else stg_q[i].valid <= 1'b0;
  assign beat_o = stg_q[STAGES-1];
endmodule

// File: rtl/dmem_bank_model.sv
// dmem_bank_model: 1W/1R data memory with byte strobes, configurable read latency,
// read-during-write policy, out-of-range detection and saturating access counters.
module dmem_bank_model
  import dmem_bank_model_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = MEM_DATA_WIDTH,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = DMEM_RD_LAT_DEFAULT,
  parameter int BYPASS = 1,
  parameter int CNT_W  = DMEM_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dmem_wen,
  input  logic [ADDR_W-1:0]   dmem_waddr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_wstrb,
  input  logic                dmem_ren,
  input  logic [ADDR_W-1:0]   dmem_raddr,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_rvalid,
  output logic                dmem_werr,
  output logic                dmem_rerr,
  output logic [CNT_W-1:0]    wr_cnt,
  output logic [CNT_W-1:0]    rd_cnt
);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dmem_bank_model: RD_LAT=%0d outside 1..4", RD_LAT);
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("dmem_bank_model: DATA_W=%0d not a multiple of 8", DATA_W);
  end
  if (DEPTH > 2**ADDR_W) begin : g_bad_depth
    $error("dmem_bank_model: DEPTH=%0d exceeds 2**ADDR_W", DEPTH);
  end

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_ok, r_ok, hit;
  logic [DATA_W-1:0] merged, rword;
  beat_t             beat0_q, beat0_d, out_beat;
  logic              werr_q, werr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  always_comb begin
    w_ok   = dmem_wen && ({1'b0, dmem_waddr} < LIMIT);
    r_ok   = dmem_ren && ({1'b0, dmem_raddr} < LIMIT);
    merged = mem[dmem_waddr];
    for (int b = 0; b < STRB_W; b++)
      if (dmem_wstrb[b]) merged[8*b +: 8] = dmem_wdata[8*b +: 8];
    // Bypass forwards the post-write word, so strobed-off bytes still come from the array.
    hit      = (BYPASS != 0) && w_ok && r_ok && (dmem_waddr == dmem_raddr);
    rword    = !r_ok ? '0 : hit ? merged : mem[dmem_raddr];
    beat0_d  = dmem_ren ? beat_t'{1'b1, !r_ok, rword} : beat_t'{1'b0, beat0_q.err, beat0_q.data};
    werr_d   = dmem_wen && !w_ok;
    wr_cnt_d = wr_cnt_q + CNT_W'(w_ok && !(&wr_cnt_q));
    rd_cnt_d = rd_cnt_q + CNT_W'(r_ok && !(&rd_cnt_q));
  end

  always_ff @(posedge clk)
    if (w_ok) mem[dmem_waddr] <= merged;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      beat0_q  <= '0;
      werr_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      beat0_q  <= beat0_d;
      werr_q   <= werr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end

  if (RD_LAT > 1) begin : g_pipe
    dmem_rd_pipe #(.STAGES(RD_LAT-1), .beat_t(beat_t)) u_pipe (
      .clk   (clk),
      .rst_n (rst),
      .beat_i(beat0_q),
      .beat_o(out_beat)
    );
  end else begin : g_direct
    assign out_beat = beat0_q;
  end

  assign dmem_rdata  = out_beat.data;
  assign dmem_rvalid = out_beat.valid;
  assign dmem_rerr   = out_beat.valid && out_beat.err;
  assign dmem_werr   = werr_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;

  task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    mem[addr] <= data;
  endtask

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
    return mem[addr];
  endfunction
endmodule

// File: tb/tb_dmem_bank_model.sv
// tb_dmem_bank_model: three configurations driven in lockstep, checked by a scoreboard monitor.
module tb_dmem_bank_model;
  localparam int N = 3;
  localparam int LAT  [N] = '{1, 3, 4};
  localparam int BYP  [N] = '{1, 0, 1};
  localparam int DEP  [N] = '{200, 256, 256};
  localparam int CMAX [N] = '{15, 65535, 65535};

  typedef struct {int due; logic err; logic [31:0] data;} rd_t;
  typedef struct {int due; logic werr; int wc; int rc;} ctl_t;

  logic clk = 1'b0, rst = 1'b0;
  logic wen = 1'b0, ren = 1'b0;
  logic [7:0] waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic [31:0] rdata [N];
  logic rvalid [N], werr [N], rerr [N];
  logic [3:0] wc0, rc0;
  logic [15:0] wc1, rc1, wc2, rc2;
  logic [15:0] wcs [N], rcs [N];

  int cyc = 0, vectors = 0, miscompares = 0, idle = 0;
  rd_t  rq [N][$];
  ctl_t cq [N][$];
  logic [31:0] mm [N][256];
  int wc_m [N], rc_m [N];
  logic [31:0] last [N];
  logic done = 1'b0, finished = 1'b0;

  assign wcs[0] = {12'b0, wc0};
  assign rcs[0] = {12'b0, rc0};
  assign wcs[1] = wc1;
  assign rcs[1] = rc1;
  assign wcs[2] = wc2;
  assign rcs[2] = rc2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bank_model #(.DEPTH(200), .RD_LAT(1), .BYPASS(1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .dmem_wen(wen), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_ren(ren), .dmem_raddr(raddr), .dmem_rdata(rdata[0]),
    .dmem_rvalid(rvalid[0]), .dmem_werr(werr[0]), .dmem_rerr(rerr[0]), .wr_cnt(wc0), .rd_cnt(rc0));
  dmem_bank_model #(.DEPTH(256), .RD_LAT(3), .BYPASS(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .dmem_wen(wen), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_ren(ren), .dmem_raddr(raddr), .dmem_rdata(rdata[1]),
    .dmem_rvalid(rvalid[1]), .dmem_werr(werr[1]), .dmem_rerr(rerr[1]), .wr_cnt(wc1), .rd_cnt(rc1));
  dmem_bank_model #(.DEPTH(256), .RD_LAT(4), .BYPASS(1), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .dmem_wen(wen), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_ren(ren), .dmem_raddr(raddr), .dmem_rdata(rdata[2]),
    .dmem_rvalid(rvalid[2]), .dmem_werr(werr[2]), .dmem_rerr(rerr[2]), .wr_cnt(wc2), .rd_cnt(rc2));

  task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", n, i, cyc, a, e);
    end
  endtask

  // Monitor: compares DUT outputs against whatever the scoreboard says is due this cycle.
  always @(negedge clk) begin
    int pending;
    pending = 0;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        chk("rst_rvalid", i, 32'(rvalid[i]), 32'd0);
        chk("rst_rdata", i, rdata[i], 32'd0);
        chk("rst_rerr", i, 32'(rerr[i]), 32'd0);
        chk("rst_werr", i, 32'(werr[i]), 32'd0);
        chk("rst_wr_cnt", i, 32'(wcs[i]), 32'd0);
        chk("rst_rd_cnt", i, 32'(rcs[i]), 32'd0);
        last[i] = '0;
      end else begin
        if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
          chk("rvalid", i, 32'(rvalid[i]), 32'd1);
          chk("rdata", i, rdata[i], rq[i][0].data);
          chk("rerr", i, 32'(rerr[i]), 32'(rq[i][0].err));
          last[i] = rq[i][0].data;
          void'(rq[i].pop_front());
        end else begin
          chk("rvalid_idle", i, 32'(rvalid[i]), 32'd0);
          chk("rdata_hold", i, rdata[i], last[i]);
          chk("rerr_idle", i, 32'(rerr[i]), 32'd0);
        end
        if (cq[i].size() > 0 && cq[i][0].due == cyc) begin
          chk("werr", i, 32'(werr[i]), 32'(cq[i][0].werr));
          chk("wr_cnt", i, 32'(wcs[i]), 32'(cq[i][0].wc));
          chk("rd_cnt", i, 32'(rcs[i]), 32'(cq[i][0].rc));
          void'(cq[i].pop_front());
        end
      end
      pending += rq[i].size() + cq[i].size();
    end
    if (done && !finished) begin
      idle++;
      if (pending == 0) finished = 1'b1;
      else if (idle > 50) begin
        chk("drain", 0, 32'(pending), 32'd0);
        finished = 1'b1;
      end
    end
  end

  // Drives one edge worth of inputs and records what each configuration must produce.
  task automatic step(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic re, input logic [7:0] ra);
    int e;
    e = cyc + 1;
    wen = we; waddr = wa; wdata = wd; wstrb = ws; ren = re; raddr = ra;
    for (int i = 0; i < N; i++) begin
      logic [31:0] old, nw;
      logic wok, rok;
      rd_t r;
      ctl_t c;
      wok = we && (int'(wa) < DEP[i]);
      rok = re && (int'(ra) < DEP[i]);
      old = mm[i][ra];
      nw  = mm[i][wa];
      for (int b = 0; b < 4; b++) if (ws[b]) nw[8*b +: 8] = wd[8*b +: 8];
      if (re) begin
        r.due  = e + LAT[i] - 1;
        r.err  = !rok;
        r.data = !rok ? 32'd0 : (wok && wa == ra && BYP[i] == 1) ? nw : old;
        rq[i].push_back(r);
      end
      if (wok) mm[i][wa] = nw;
      if (wok && wc_m[i] < CMAX[i]) wc_m[i]++;
      if (rok && rc_m[i] < CMAX[i]) rc_m[i]++;
      c.due = e; c.werr = we && !wok; c.wc = wc_m[i]; c.rc = rc_m[i];
      cq[i].push_back(c);
    end
    @(posedge clk); #1;
  endtask

  task automatic nop();
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, a);
  endtask

  task automatic do_reset();
    wen = 1'b0; ren = 1'b0; rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i].delete(); cq[i].delete(); wc_m[i] = 0; rc_m[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin wc_m[i] = 0; rc_m[i] = 0; last[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int a = 0; a < 256; a++) step(1'b1, 8'(a), 32'(a + 'h100), 4'hF, 1'b0, 8'd0);
    step(1'b1, 8'd3, 32'hDEADBEEF, 4'hF, 1'b0, 8'd0); nop(); nop(); rd(8'd3); nop();
    step(1'b1, 8'd5, 32'h11223344, 4'hF, 1'b0, 8'd0);
    step(1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 8'd0); rd(8'd5); nop();
    step(1'b1, 8'd7, 32'h0, 4'hF, 1'b0, 8'd0);
    step(1'b1, 8'd7, 32'hCAFEF00D, 4'hF, 1'b1, 8'd7); rd(8'd7); nop();
    rd(8'd0); rd(8'd1); rd(8'd2); repeat (4) nop();
    step(1'b1, 8'd250, 32'h12345678, 4'hF, 1'b0, 8'd0); rd(8'd250); nop();
    step(1'b1, 8'd9, 32'h0, 4'd0, 1'b0, 8'd0);
    rd(8'd9); nop(); nop();
    do_reset();
    rd(8'd3); rd(8'd5); rd(8'd7); rd(8'd9); repeat (4) nop();
    for (int k = 0; k < 20; k++) step(1'b1, 8'($urandom_range(0, 199)), $urandom, 4'hF, 1'b0, 8'd0);
    for (int k = 0; k < 400; k++) begin
      automatic logic [7:0] wa = 8'($urandom);
      automatic logic [7:0] ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom);
      if (k == 200) do_reset();
      step(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom), ra);
    end
    repeat (6) nop();
    done = 1'b1;
    wait (finished);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
